// File: rtl/uart_rx.sv
// 8N1 UART receiver. The line is oversampled on the rxclk_en strobe, and each byte is
// held with a sticky ready flag until the consumer acknowledges it.
module uart_rx #(
  parameter int unsigned SAMPLE_MULTIPLIER = 16,
  parameter int unsigned DATA_BITS         = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rxclk_en,
  input  logic                 rx,
  input  logic                 rdy_clr,
  output logic [DATA_BITS-1:0] data,
  output logic                 rdy,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  localparam logic [7:0] HalfLast = 8'(SAMPLE_MULTIPLIER / 2 - 1);
  localparam logic [7:0] BitLast  = 8'(SAMPLE_MULTIPLIER - 1);
  localparam logic [3:0] IdxLast  = 4'(DATA_BITS - 1);

  state_e               state_q;
  logic [7:0]           cnt_q;
  logic [3:0]           bit_idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [1:0]           sync_q;
  logic                 rx_s;

  // Flops reset high so the idle line is not mistaken for a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx};
    end
  end

  assign rx_s = sync_q[1];
  assign busy = (state_q != StIdle);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data      <= '0;
      rdy       <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (rdy_clr) begin
        rdy     <= 1'b0;
        overrun <= 1'b0;
      end
      if (rxclk_en) begin
        unique case (state_q)
          StIdle: begin
            if (!rx_s) begin
              state_q <= StStart;
              cnt_q   <= '0;
            end
          end
          StStart: begin
            if (cnt_q == HalfLast) begin
              cnt_q <= '0;
              if (!rx_s) begin
                state_q   <= StData;
                bit_idx_q <= '0;
              end else begin
                state_q <= StIdle;
              end
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
          StData: begin
            if (cnt_q == BitLast) begin
              cnt_q   <= '0;
              shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
              if (bit_idx_q == IdxLast) begin
                state_q <= StStop;
              end else begin
                bit_idx_q <= bit_idx_q + 4'd1;
              end
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
          StStop: begin
            // Returning at mid-stop leaves half a bit to catch a back-to-back start.
            if (cnt_q == BitLast) begin
              cnt_q   <= '0;
              state_q <= StIdle;
              if (rx_s) begin
                data      <= shift_q;
                rdy       <= 1'b1;
                frame_err <= 1'b0;
                if (rdy && !rdy_clr) begin
                  overrun <= 1'b1;
                end
              end else begin
                frame_err <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a table of whole frames plus hand-written corner sequences.
module tb_uart_rx;

  logic       clk;
  logic       rst_n;
  logic       rxclk_en;
  logic       rx;
  logic       rdy_clr;
  logic [7:0] data;
  logic       rdy;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  logic [1:0] ph;
  int         n_cmp;
  int         n_err;

  typedef struct {
    logic       clr;
    logic [7:0] din;
    logic       stop;
    int         gap;
    logic [7:0] e_data;
    logic       e_rdy;
    logic       e_fe;
    logic       e_ov;
  } vec_t;

  vec_t vecs[5];

  uart_rx #(
    .SAMPLE_MULTIPLIER(16),
    .DATA_BITS        (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rxclk_en (rxclk_en),
    .rx       (rx),
    .rdy_clr  (rdy_clr),
    .data     (data),
    .rdy      (rdy),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe on every 4th clock: 16 ticks per bit gives 64 clocks per bit.
  initial begin
    ph       = 2'd0;
    rxclk_en = 1'b0;
  end
  always @(negedge clk) begin
    ph       = ph + 2'd1;
    rxclk_en = (ph == 2'd0);
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Leaves us just after a negedge whose following posedge carries a tick.
  task automatic align();
    do begin
      @(negedge clk);
      #1;
    end while (ph != 2'd0);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int nbits);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      rx = f[i];
      repeat (64) @(negedge clk);
      #1;
    end
    rx = 1'b1;
  endtask

  task automatic pulse_clr();
    rdy_clr = 1'b1;
    @(negedge clk);
    #1;
    rdy_clr = 1'b0;
  endtask

  task automatic chk_all(input string tag, input logic [7:0] e_data, input logic e_rdy,
                         input logic e_fe, input logic e_ov);
    chk({tag, ".data"}, data, e_data);
    chk({tag, ".rdy"}, {7'd0, rdy}, {7'd0, e_rdy});
    chk({tag, ".frame_err"}, {7'd0, frame_err}, {7'd0, e_fe});
    chk({tag, ".overrun"}, {7'd0, overrun}, {7'd0, e_ov});
    chk({tag, ".busy"}, {7'd0, busy}, 8'd0);
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    rst_n   = 1'b0;
    rx      = 1'b1;
    rdy_clr = 1'b0;

    //          clr   din    stop  gap  data   rdy   fe    ov
    vecs[0] = '{1'b0, 8'hA5, 1'b1, 2, 8'hA5, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 8'h3C, 1'b0, 2, 8'hA5, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 8'h81, 1'b1, 2, 8'h81, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 8'h11, 1'b1, 0, 8'h11, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 8'h22, 1'b1, 2, 8'h22, 1'b1, 1'b0, 1'b1};

    idle(3);
    chk_all("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    idle(16);

    for (int i = 0; i < 5; i++) begin
      if (vecs[i].clr) pulse_clr();
      align();
      send_frame(vecs[i].din, vecs[i].stop, 10);
      idle(vecs[i].gap * 64);
      chk_all($sformatf("vec%0d", i), vecs[i].e_data, vecs[i].e_rdy, vecs[i].e_fe,
              vecs[i].e_ov);
    end

    // Acknowledge clears both rdy and overrun, data is kept.
    pulse_clr();
    idle(2);
    chk_all("ack", 8'h22, 1'b0, 1'b0, 1'b0);

    // Six-tick glitch: enters START, then rejected at mid-bit.
    align();
    rx = 1'b0;
    repeat (24) @(negedge clk);
    #1;
    rx = 1'b1;
    chk("glitch.busy_mid", {7'd0, busy}, 8'd1);
    idle(64);
    chk_all("glitch", 8'h22, 1'b0, 1'b0, 1'b0);

    align();
    send_frame(8'h55, 1'b1, 10);
    idle(128);
    chk_all("after_glitch", 8'h55, 1'b1, 1'b0, 1'b0);

    // rdy_clr lands on the mid-stop tick, 612 clocks after the start edge.
    align();
    fork
      send_frame(8'h66, 1'b1, 10);
      begin
        repeat (612) @(posedge clk);
        #1;
        rdy_clr = 1'b1;
        @(posedge clk);
        #1;
        rdy_clr = 1'b0;
      end
    join
    idle(128);
    chk_all("clr_same_cycle", 8'h66, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of a byte, after three data bits.
    align();
    send_frame(8'h0F, 1'b1, 4);
    chk("midbyte.busy", {7'd0, busy}, 8'd1);
    rst_n = 1'b0;
    #1;
    chk_all("midbyte_reset", 8'h00, 1'b0, 1'b0, 1'b0);
    idle(4);
    rst_n = 1'b1;
    idle(64);
    align();
    send_frame(8'hF0, 1'b1, 10);
    idle(128);
    chk_all("after_reset", 8'hF0, 1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
